// File: rtl/retire_checker.sv
// Retire-stream checker: buffers DUT retire records and compares them in order against golden-model records.
// Optional watchdog enabled by defining RETIRE_CHECKER_TIMEOUT_EN.
module retire_checker #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   input  logic        rdv,
   input  logic [4:0]  rd_x,
   input  logic [31:0] rd_data,
   input  logic        pcv,
   input  logic [31:0] pc_x,
   input  logic        exp_valid,
   output logic        exp_ready,
   input  logic [31:0] exp_pc,
   input  logic [31:0] exp_inst,
   input  logic [31:0] exp_rd_data,
   input  logic [31:0] exp_pc_x,
   input  logic        exp_rdv,
   input  logic        exp_pcv,
   input  logic [4:0]  exp_rd_x,
   input  logic        stop_on_err,
   input  logic        clr,
   output logic        mismatch,
   output logic [2:0]  mismatch_code,
   output logic [31:0] match_count,
   output logic [15:0] err_count,
   output logic        overflow,
   output logic        timeout,
   output logic        halted
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        rdv;
      logic [4:0]  rd_x;
      logic [31:0] rd_data;
      logic        pcv;
      logic [31:0] pc_x;
   } rec_t;

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_reg, state_next;
   rec_t        mem_reg [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0] count_reg;

   logic        mismatch_reg;
   logic [2:0]  mismatch_code_reg;
   logic [31:0] match_count_reg;
   logic [15:0] err_count_reg;
   logic        overflow_reg;

   logic        empty, full, hs, push_ok, drop, wd_hit;
   rec_t        push_rec, head;
   logic [2:0]  cmp_code;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == FULL_CNT);
   assign exp_ready = (state_reg == RUN) && !empty;
   assign hs        = exp_valid && exp_ready;
   assign push_ok   = valid && (!full || hs);
   assign drop      = valid && full && !hs;
   assign push_rec  = '{pc: pc, inst: inst, rdv: rdv, rd_x: rd_x, rd_data: rd_data, pcv: pcv, pc_x: pc_x};
   assign head      = mem_reg[rd_ptr_reg];

   // Field compare in priority order; rd_data is a don't-care for writes to x0.
   always_comb begin
      cmp_code = 3'd0;
      if (head.pc != exp_pc)
         cmp_code = 3'd1;
      else if (head.inst != exp_inst)
         cmp_code = 3'd2;
      else if ((head.rdv != exp_rdv) ||
               (head.rdv && exp_rdv && ((head.rd_x != exp_rd_x) ||
                                        ((head.rd_x != 5'd0) && (head.rd_data != exp_rd_data)))))
         cmp_code = 3'd3;
      else if ((head.pcv != exp_pcv) || (head.pcv && exp_pcv && (head.pc_x != exp_pc_x)))
         cmp_code = 3'd4;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_reg[wr_ptr_reg] <= push_rec;
   end

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (hs)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, hs})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Results register on the handshake edge, so a reset or clear on that edge discards them.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         mismatch_reg      <= 1'b0;
         mismatch_code_reg <= 3'd0;
         match_count_reg   <= 32'd0;
         err_count_reg     <= 16'd0;
         overflow_reg      <= 1'b0;
      end else begin
         mismatch_reg <= 1'b0;
         if (hs) begin
            if (cmp_code != 3'd0) begin
               mismatch_reg      <= 1'b1;
               mismatch_code_reg <= cmp_code;
               if (err_count_reg != 16'hFFFF)
                  err_count_reg <= err_count_reg + 16'd1;
            end else begin
               match_count_reg <= match_count_reg + 32'd1;
            end
         end
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

`ifdef RETIRE_CHECKER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wd_cnt_reg;
   logic          timeout_reg;
   logic          wd_run;

   assign wd_run = (state_reg == RUN) && !empty && !hs;
   assign wd_hit = wd_run && (wd_cnt_reg == WW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         wd_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
      end else if (wd_hit) begin
         wd_cnt_reg  <= '0;
         timeout_reg <= 1'b1;
      end else if (wd_run) begin
         wd_cnt_reg  <= wd_cnt_reg + 1'b1;
      end else begin
         wd_cnt_reg  <= '0;
      end
   end

   assign timeout = timeout_reg;
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      if (clr)
         state_next = RUN;
      else if ((state_reg == RUN) && hs && (cmp_code != 3'd0) && stop_on_err)
         state_next = HALT;
      else if (wd_hit)
         state_next = HALT;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state_reg <= RUN;
      else
         state_reg <= state_next;
   end

   assign mismatch      = mismatch_reg;
   assign mismatch_code = mismatch_code_reg;
   assign match_count   = match_count_reg;
   assign err_count     = err_count_reg;
   assign overflow      = overflow_reg;
   assign halted        = (state_reg == HALT);

endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker: compare, mismatch priority, overflow, clear, halt, reset and watchdog.
module tb_retire_checker;

   logic        clk = 1'b0;
   logic        reset, valid, rdv, pcv, exp_valid, exp_rdv, exp_pcv, stop_on_err, clr;
   logic [31:0] pc, inst, rd_data, pc_x, exp_pc, exp_inst, exp_rd_data, exp_pc_x;
   logic [4:0]  rd_x, exp_rd_x;
   logic        exp_ready, mismatch, overflow, timeout, halted;
   logic [2:0]  mismatch_code;
   logic [31:0] match_count;
   logic [15:0] err_count;

   int total = 0;
   int bad   = 0;

   retire_checker #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .valid(valid), .pc(pc), .inst(inst), .rdv(rdv),
      .rd_x(rd_x), .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc), .exp_inst(exp_inst),
      .exp_rd_data(exp_rd_data), .exp_pc_x(exp_pc_x), .exp_rdv(exp_rdv), .exp_pcv(exp_pcv),
      .exp_rd_x(exp_rd_x), .stop_on_err(stop_on_err), .clr(clr),
      .mismatch(mismatch), .mismatch_code(mismatch_code), .match_count(match_count),
      .err_count(err_count), .overflow(overflow), .timeout(timeout), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic set_default();
      pc = 32'h100; inst = 32'h00500093; rdv = 1'b1; rd_x = 5'd1; rd_data = 32'h5;
      pcv = 1'b0; pc_x = 32'h0;
      exp_pc = 32'h100; exp_inst = 32'h00500093; exp_rdv = 1'b1; exp_rd_x = 5'd1;
      exp_rd_data = 32'h5; exp_pcv = 1'b0; exp_pc_x = 32'h0;
   endtask

   // Push the current DUT record, then present the current expected record for one handshake.
   task automatic one_compare();
      valid = 1'b1;
      tick();
      valid = 1'b0;
      exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
   endtask

   logic exp_to;

   initial begin
      reset = 1'b0; valid = 1'b0; exp_valid = 1'b0; stop_on_err = 1'b0; clr = 1'b0;
      set_default();
      tick(); tick();
      chk("rst_mismatch", mismatch, 0);
      chk("rst_code", mismatch_code, 0);
      chk("rst_match", match_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_halted", halted, 0);
      chk("rst_ready", exp_ready, 0);
      reset = 1'b1;
      tick();

      // three identical records
      for (int i = 0; i < 3; i++) begin
         one_compare();
         chk("ident_nomis", mismatch, 0);
      end
      chk("ident_match", match_count, 3);
      chk("ident_err", err_count, 0);

      // pc and inst both differ: pc wins
      set_default(); pc = 32'h104; inst = 32'h00600093;
      one_compare();
      chk("pri_mis", mismatch, 1);
      chk("pri_code", mismatch_code, 1);
      tick();
      chk("pulse_one", mismatch, 0);

      // rd_data differs on a non-x0 write
      set_default(); rd_x = 5'd5; exp_rd_x = 5'd5; exp_rd_data = 32'h6;
      one_compare();
      chk("rdd_code", mismatch_code, 3);

      // pcv differs
      set_default(); exp_pcv = 1'b1; exp_pc_x = 32'h400;
      one_compare();
      chk("pcv_code", mismatch_code, 4);
      chk("pcv_err", err_count, 3);
      chk("pcv_halted", halted, 0);

      // x0 write data is ignored
      set_default(); rd_x = 5'd0; exp_rd_x = 5'd0; rd_data = 32'h1; exp_rd_data = 32'h2;
      one_compare();
      chk("x0_nomis", mismatch, 0);
      chk("x0_match", match_count, 4);
      chk("x0_code", mismatch_code, 4);

      // inst mismatch with stop_on_err, one record left behind
      set_default(); inst = 32'h00600093; stop_on_err = 1'b1;
      valid = 1'b1;
      tick();
      exp_valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("halt_mis", mismatch, 1);
      chk("halt_code", mismatch_code, 2);
      chk("halt_halted", halted, 1);
      chk("halt_ready", exp_ready, 0);
      tick();
      exp_valid = 1'b0;
      chk("halt_err", err_count, 4);
      chk("halt_mis_off", mismatch, 0);

      // buffering continues in HALT: 1 + 3 fills, next one overflows
      valid = 1'b1;
      repeat (3) tick();
      chk("halt_full_noovf", overflow, 0);
      tick();
      valid = 1'b0;
      chk("halt_ovf", overflow, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_ovf", overflow, 0);
      chk("clr_err", err_count, 0);
      chk("clr_match", match_count, 0);
      chk("clr_code", mismatch_code, 0);
      chk("clr_halted", halted, 0);
      chk("clr_ready", exp_ready, 0);
      stop_on_err = 1'b0;

      // five records into a depth-4 buffer with no consumer
      set_default();
      for (int i = 0; i < 5; i++) begin
         pc = 32'h200 + 32'(4 * i);
         valid = 1'b1;
         tick();
         if (i == 3) chk("ovf_at4", overflow, 0);
      end
      valid = 1'b0;
      chk("ovf_at5", overflow, 1);
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'h200 + 32'(4 * i);
         exp_valid = 1'b1;
         tick();
      end
      exp_valid = 1'b0;
      chk("ovf_buffered", match_count, 4);
      chk("ovf_err", err_count, 0);
      chk("ovf_empty", exp_ready, 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr2_ovf", overflow, 0);
      chk("clr2_match", match_count, 0);

      // full buffer with simultaneous push and pop does not overflow
      set_default();
      for (int i = 0; i < 4; i++) begin
         pc = 32'h300 + 32'(4 * i);
         valid = 1'b1;
         tick();
      end
      pc = 32'h310; exp_pc = 32'h300; exp_valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("pp_noovf", overflow, 0);
      for (int i = 1; i < 5; i++) begin
         exp_pc = 32'h300 + 32'(4 * i);
         tick();
      end
      exp_valid = 1'b0;
      chk("pp_match", match_count, 5);
      chk("pp_err", err_count, 0);

      // reset on the handshake edge discards the result
      set_default(); inst = 32'h00600093;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      exp_valid = 1'b1;
      reset = 1'b0;
      tick();
      exp_valid = 1'b0;
      chk("rstmid_mis", mismatch, 0);
      chk("rstmid_err", err_count, 0);
      reset = 1'b1;
      tick();
      chk("rstmid_mis2", mismatch, 0);
      chk("rstmid_ready", exp_ready, 0);

      // watchdog
`ifdef RETIRE_CHECKER_TIMEOUT_EN
      exp_to = 1'b1;
`else
      exp_to = 1'b0;
`endif
      set_default();
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (15) tick();
      chk("wd_before", timeout, 0);
      tick();
      chk("wd_timeout", timeout, 32'(exp_to));
      chk("wd_halted", halted, 32'(exp_to));
      repeat (4) tick();
      chk("wd_sticky", timeout, 32'(exp_to));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/retire_checker.md
RETIRE_CHECKER -- requirements
Module: retire_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): DUT retire-record buffer depth.
REQ-002 SHALL have parameter TIMEOUT, default 1024: max cycles a buffered record waits for an expected record.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- valid  in  1  DUT retire record present (no backpressure).
- pc, inst  in  32 each  retired PC and instruction word.
- rdv  in  1  register write valid.
- rd_x  in  5  destination register.
- rd_data  in  32  write data.
- pcv  in  1  PC redirect valid.
- pc_x  in  32  redirect target.
- exp_valid  in  1  golden-model record valid.
- exp_ready  out  1  golden record consumed.
- exp_pc, exp_inst, exp_rd_data, exp_pc_x  in  32 each  expected fields.
- exp_rdv, exp_pcv  in  1 each.
- exp_rd_x  in  5.
- stop_on_err  in  1  halt on first mismatch.
- clr  in  1  one-cycle clear pulse.
- mismatch  out  1  one-cycle mismatch pulse.
- mismatch_code  out  3  field code of the last mismatch.
- match_count  out  32  compared-equal records.
- err_count  out  16  mismatches, saturating.
- overflow, timeout, halted  out  1 each  sticky flags.

Function
REQ-004 On valid=1, the record {pc,inst,rdv,rd_x,rd_data,pcv,pc_x} SHALL be pushed into the FIFO.
REQ-005 A push while full with no same-cycle pop SHALL drop the record and set overflow; push and pop in the same cycle while full SHALL NOT set overflow.
REQ-006 exp_ready SHALL be 1 iff state is RUN and the FIFO is not empty; exp_valid & exp_ready SHALL pop one FIFO record and compare it.
REQ-007 Compare SHALL apply in priority order, first failing code reported: 1 pc; 2 inst; 3 rdv differs, or both rdv with rd_x differing, or both rdv with rd_x!=0 and rd_data differing; 4 pcv differs, or both pcv with pc_x differing; 0 equal.
REQ-008 When both rdv=1 and rd_x=0, rd_data SHALL be ignored.
REQ-009 Compare result SHALL register one cycle after the handshake: mismatch pulses 1 for one cycle and mismatch_code updates when nonzero; otherwise match_count increments (wraps at 2^32).
REQ-010 err_count SHALL increment per mismatch and saturate at 16'hFFFF.
REQ-011 States SHALL be RUN and HALT; mismatch with stop_on_err=1 SHALL go RUN->HALT on the result cycle; halted=1 in HALT.
REQ-012 In HALT, exp_ready SHALL be 0, DUT pushes SHALL continue to buffer, and overflow rules SHALL still apply.
REQ-013 clr=1 SHALL flush the FIFO, zero counters, mismatch_code and sticky flags, and enter RUN next cycle; an in-flight handshake in that cycle SHALL be discarded.
REQ-014 clr SHALL take priority over simultaneous push, pop or mismatch.

Reset
REQ-015 reset=0 at a rising edge SHALL empty the FIFO, enter RUN, and drive every output to 0 except exp_ready, which follows REQ-006 (0 with the FIFO empty).
REQ-016 Reset mid-compare SHALL discard the pending result with no mismatch pulse.

Configuration
REQ-017 With RETIRE_CHECKER_TIMEOUT_EN defined, a watchdog SHALL count cycles where the FIFO is non-empty in RUN with no handshake, reset on each handshake or empty FIFO, and on reaching TIMEOUT set timeout and go to HALT.
REQ-018 Without RETIRE_CHECKER_TIMEOUT_EN, timeout SHALL be constant 0 and no watchdog logic SHALL exist.

Verification
REQ-019 3 identical records, exp_valid=1 -> match_count=3, err_count=0, no mismatch pulse.
REQ-020 Expected inst 0x00500093, DUT inst 0x00600093, same pc, stop_on_err=1 -> mismatch pulse, code=2, halted=1, exp_ready=0.
REQ-021 rd_x=0 on both sides, rd_data 0x1 vs 0x2 -> match, code unchanged.
REQ-022 exp_valid=0, 5 DUT records, FIFO_DEPTH=4 -> overflow=1, 4 records buffered; then clr -> all flags and counters 0.
REQ-023 With macro, TIMEOUT=16, one record, exp_valid=0 -> timeout=1 and halted=1 after 16 cycles; without macro -> timeout stays 0.
